// File: rtl/cva6_commit_trace_buffer.sv
// ============================================================================
// Module   : cva6_commit_trace_buffer
// Brief    : Captures up to two retired instructions per cycle into a
//            circular buffer and drains them one per cycle over a
//            valid/ready stream. Overflowing commits are dropped and counted.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module cva6_commit_trace_buffer #(
    parameter int unsigned Depth        = 16,
    parameter int unsigned XLEN         = 64,
    parameter int unsigned DropCntWidth = 32
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         enable_i,
    input  logic                         flush_i,
    input  logic [1:0]                   commit_valid_i,
    input  logic [1:0][XLEN-1:0]         commit_pc_i,
    input  logic [1:0][31:0]             commit_insn_i,
    input  logic [1:0]                   commit_exc_i,
    output logic                         trace_valid_o,
    input  logic                         trace_ready_i,
    output logic [XLEN-1:0]              trace_pc_o,
    output logic [31:0]                  trace_insn_o,
    output logic                         trace_exc_o,
    output logic [$clog2(Depth):0]       count_o,
    output logic [DropCntWidth-1:0]      drop_cnt_o
);

    localparam int unsigned PtrW = $clog2(Depth);
    localparam int unsigned CntW = PtrW + 1;

    // Entry storage; deliberately not reset (only pointers define validity)
    logic [XLEN-1:0]         ram_pc_q   [Depth];
    logic [31:0]             ram_insn_q [Depth];
    logic                    ram_exc_q  [Depth];

    logic [PtrW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]         count_q, count_d;
    logic [DropCntWidth-1:0] drop_cnt_q, drop_cnt_d;

    logic                    head_valid;
    logic                    pop;
    logic [CntW:0]           free;
    logic [1:0]              cand;
    logic [1:0]              acc;
    logic [1:0]              n_acc;
    logic [1:0]              n_drop;
    logic [DropCntWidth:0]   drop_sum;
    logic [1:0][PtrW-1:0]    wr_addr;

    assign head_valid = (count_q != '0);

    // Push acceptance, compaction, drop accounting and next-state pointers
    always_comb begin
        pop        = head_valid & trace_ready_i;
        // A same-cycle pop frees one slot for the incoming pushes
        free       = (CntW+1)'(Depth) - {1'b0, count_q} + (CntW+1)'(pop);
        cand       = enable_i ? commit_valid_i : 2'b00;
        // Port 0 is older, so it always gets the first free slot
        acc[0]     = cand[0] & (free != '0);
        acc[1]     = cand[1] & (cand[0] ? (free >= (CntW+1)'(2)) : (free != '0));
        n_acc      = {1'b0, acc[0]} + {1'b0, acc[1]};
        n_drop     = {1'b0, cand[0] & ~acc[0]} + {1'b0, cand[1] & ~acc[1]};
        // Port 1 lands right behind port 0 only when port 0 was written
        wr_addr[0] = wr_ptr_q;
        wr_addr[1] = wr_ptr_q + PtrW'(acc[0]);
        drop_sum   = {1'b0, drop_cnt_q} + (DropCntWidth+1)'(n_drop);
        drop_cnt_d = drop_sum[DropCntWidth] ? '1 : drop_sum[DropCntWidth-1:0];
        wr_ptr_d   = wr_ptr_q + PtrW'(n_acc);
        rd_ptr_d   = rd_ptr_q + PtrW'(pop);
        count_d    = count_q + CntW'(n_acc) - CntW'(pop);
        // Flush empties the buffer, discards this cycle's commits, keeps drops
        if (flush_i) begin
            acc        = 2'b00;
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            count_d    = '0;
            drop_cnt_d = drop_cnt_q;
        end
    end

    // Pointer, occupancy and drop-counter registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            drop_cnt_q <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    // Entry RAM writes for accepted commits (ignored while in reset)
    always_ff @(posedge clk_i) begin
        for (int p = 0; p < 2; p++) begin
            if (acc[p] && !rst_i) begin
                ram_pc_q[wr_addr[p]]   <= commit_pc_i[p];
                ram_insn_q[wr_addr[p]] <= commit_insn_i[p];
                ram_exc_q[wr_addr[p]]  <= commit_exc_i[p];
            end
        end
    end

    // First-word fall-through head, zeroed while empty
    assign trace_valid_o = head_valid;
    assign trace_pc_o    = head_valid ? ram_pc_q[rd_ptr_q]   : '0;
    assign trace_insn_o  = head_valid ? ram_insn_q[rd_ptr_q] : '0;
    assign trace_exc_o   = head_valid ? ram_exc_q[rd_ptr_q]  : 1'b0;
    assign count_o       = count_q;
    assign drop_cnt_o    = drop_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_cva6_commit_trace_buffer.sv
// ============================================================================
// Module   : tb_cva6_commit_trace_buffer
// Brief    : Directed and random stimulus for the commit trace buffer,
//            checked against a queue-based reference model.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_cva6_commit_trace_buffer;

    localparam int DEPTH = 16;
    localparam int XLEN  = 64;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 enable;
    logic                 flush;
    logic                 ready;
    logic [1:0]           cv;
    logic [1:0][XLEN-1:0] cpc;
    logic [1:0][31:0]     cinsn;
    logic [1:0]           cexc;

    logic                 tv, tv_s;
    logic [XLEN-1:0]      tpc, tpc_s;
    logic [31:0]          tinsn, tinsn_s;
    logic                 texc, texc_s;
    logic [4:0]           cnt, cnt_s;
    logic [31:0]          drop;
    logic [3:0]           drop_s;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [31:0]     insn;
        logic            exc;
    } ent_t;

    ent_t   mq[$];
    longint mdrops;
    int     vectors;
    int     miscompares;
    longint saved_drops;

    always #5 clk = ~clk;

    cva6_commit_trace_buffer #(.Depth(DEPTH), .XLEN(XLEN), .DropCntWidth(32)) dut (
        .clk_i(clk), .rst_i(rst), .enable_i(enable), .flush_i(flush),
        .commit_valid_i(cv), .commit_pc_i(cpc), .commit_insn_i(cinsn),
        .commit_exc_i(cexc), .trace_valid_o(tv), .trace_ready_i(ready),
        .trace_pc_o(tpc), .trace_insn_o(tinsn), .trace_exc_o(texc),
        .count_o(cnt), .drop_cnt_o(drop)
    );

    cva6_commit_trace_buffer #(.Depth(DEPTH), .XLEN(XLEN), .DropCntWidth(4)) dut_sat (
        .clk_i(clk), .rst_i(rst), .enable_i(enable), .flush_i(flush),
        .commit_valid_i(cv), .commit_pc_i(cpc), .commit_insn_i(cinsn),
        .commit_exc_i(cexc), .trace_valid_o(tv_s), .trace_ready_i(ready),
        .trace_pc_o(tpc_s), .trace_insn_o(tinsn_s), .trace_exc_o(texc_s),
        .count_o(cnt_s), .drop_cnt_o(drop_s)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Compare every DUT output against the model's view of the buffer
    task automatic check_all();
        ent_t h;
        h = (mq.size() != 0) ? mq[0] : '0;
        chk("valid",     64'(tv),    64'(mq.size() != 0));
        chk("count",     64'(cnt),   64'(mq.size()));
        chk("head_pc",   tpc,        h.pc);
        chk("head_insn", 64'(tinsn), 64'(h.insn));
        chk("head_exc",  64'(texc),  64'(h.exc));
        chk("drop",      64'(drop),  64'(mdrops));
        chk("sat_drop",  64'(drop_s), 64'((mdrops > 15) ? 15 : mdrops));
        chk("sat_count", 64'(cnt_s), 64'(mq.size()));
        chk("sat_pc",    tpc_s,      h.pc);
    endtask

    // Apply one clock edge to the model using the currently driven inputs
    task automatic model_update();
        ent_t e;
        if (rst) begin
            mq.delete();
            mdrops = 0;
        end else if (flush) begin
            mq.delete();
        end else begin
            if (mq.size() != 0 && ready) void'(mq.pop_front());
            for (int p = 0; p < 2; p++) begin
                if (enable && cv[p]) begin
                    if (mq.size() < DEPTH) begin
                        e.pc = cpc[p]; e.insn = cinsn[p]; e.exc = cexc[p];
                        mq.push_back(e);
                    end else begin
                        mdrops++;
                    end
                end
            end
        end
    endtask

    task automatic step();
        @(negedge clk);
        check_all();
        model_update();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic en, input logic fl, input logic [1:0] v,
                         input logic [63:0] p0, input logic [63:0] p1, input logic rdy);
        enable   = en;
        flush    = fl;
        cv       = v;
        cpc[0]   = p0;
        cpc[1]   = p1;
        cinsn[0] = $urandom;
        cinsn[1] = $urandom;
        cexc     = 2'($urandom);
        ready    = rdy;
    endtask

    initial begin
        vectors = 0; miscompares = 0; mdrops = 0;
        rst = 1'b1;
        drive(1'b0, 1'b0, 2'b00, 64'h0, 64'h0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Basic dual commit with draining sink
        drive(1'b1, 1'b0, 2'b11, 64'h1000, 64'h1004, 1'b1);
        step();
        chk("first_pc", tpc, 64'h1000);
        drive(1'b1, 1'b0, 2'b00, 64'h0, 64'h0, 1'b1);
        step();
        chk("second_pc", tpc, 64'h1004);
        step();
        chk("empty_after", 64'(tv), 64'h0);

        // Fill with stalled sink: 20 commits, 16 fit
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 1'b0, 2'b11, 64'h2000 + 64'(8*i), 64'h2004 + 64'(8*i), 1'b0);
            step();
            if (i == 7) chk("full_at_8", 64'(cnt), 64'd16);
        end
        chk("fill_drops", 64'(drop), 64'd4);

        // Full with pop and dual push: port 0 in, port 1 dropped
        drive(1'b1, 1'b0, 2'b11, 64'h3000, 64'h3004, 1'b1);
        step();
        chk("full_dual_cnt",  64'(cnt),  64'd16);
        chk("full_dual_drop", 64'(drop), 64'd5);
        // Full with pop and only port 1: accepted
        drive(1'b1, 1'b0, 2'b10, 64'h0, 64'h3100, 1'b1);
        step();
        chk("full_p1_drop", 64'(drop), 64'd5);
        drive(1'b1, 1'b0, 2'b00, 64'h0, 64'h0, 1'b1);
        repeat (17) step();

        // Wrap test from a clean pointer state
        rst = 1'b1; step(); rst = 1'b0;
        for (int i = 0; i < 15; i++) begin
            drive(1'b1, 1'b0, 2'b01, 64'h4000 + 64'(4*i), 64'h0, 1'b1);
            step();
        end
        drive(1'b1, 1'b0, 2'b11, 64'h5000, 64'h5004, 1'b1);
        step();
        chk("wrap_head0", tpc, 64'h5000);
        drive(1'b1, 1'b0, 2'b00, 64'h0, 64'h0, 1'b1);
        step();
        chk("wrap_head1", tpc, 64'h5004);
        repeat (2) step();

        // Overflow 20 commits: 4-bit counter saturates at 15
        rst = 1'b1; step(); rst = 1'b0;
        for (int i = 0; i < 18; i++) begin
            drive(1'b1, 1'b0, 2'b11, 64'h6000 + 64'(8*i), 64'h6004 + 64'(8*i), 1'b0);
            step();
        end
        chk("ovf_drop", 64'(drop), 64'd20);
        chk("ovf_sat",  64'(drop_s), 64'd15);

        // Drain to five entries, then flush alongside a dual commit
        drive(1'b1, 1'b0, 2'b00, 64'h0, 64'h0, 1'b1);
        repeat (11) step();
        chk("pre_flush_cnt", 64'(cnt), 64'd5);
        saved_drops = mdrops;
        drive(1'b1, 1'b1, 2'b11, 64'h7000, 64'h7004, 1'b0);
        step();
        chk("flush_cnt",   64'(cnt),  64'd0);
        chk("flush_valid", 64'(tv),   64'd0);
        chk("flush_drop",  64'(drop), 64'(saved_drops));

        // Disabled capture: commits neither stored nor counted
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b0, 2'b11, 64'h8000, 64'h8004, 1'b0);
            step();
        end
        chk("dis_cnt",  64'(cnt),  64'd0);
        chk("dis_drop", 64'(drop), 64'd20);

        // Random traffic against the reference model
        for (int i = 0; i < 300; i++) begin
            drive(($urandom_range(0, 9) != 0), ($urandom_range(0, 39) == 0), 2'($urandom),
                  {$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom));
            step();
        end
        drive(1'b1, 1'b0, 2'b00, 64'h0, 64'h0, 1'b1);
        repeat (18) step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire
